// File: rtl/llc_req_arbiter.sv
// Round-robin arbiter sharing one LLC responder port among NREQ requesters,
// one single-flit request and its BURST-beat reply at a time.
module llc_req_arbiter #(
  parameter int DATA_W = 64,
  parameter int NREQ   = 4,
  parameter int BURST  = 4,
  parameter int TO_CYC = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_si,
  output logic [NREQ-1:0]        req_ri,
  input  logic [NREQ*DATA_W-1:0] req_di,
  output logic [NREQ-1:0]        rsp_so,
  input  logic [NREQ-1:0]        rsp_ro,
  output logic [DATA_W-1:0]      rsp_do,
  output logic                   llc_so,
  input  logic                   llc_ri,
  output logic [DATA_W-1:0]      llc_do,
  input  logic                   llc_si,
  output logic                   llc_ro,
  input  logic [DATA_W-1:0]      llc_di,
  output logic                   busy,
  output logic [2:0]             owner,
  output logic                   to_err
);

  localparam int OW = $clog2(NREQ);
  localparam int TW = 16;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_t;

  state_t            state, state_nxt;
  logic [OW-1:0]     rr_ptr, owner_q, win, idx;
  logic              win_vld;
  logic [DATA_W-1:0] hold;
  logic [7:0]        beat_cnt;
  logic [TW-1:0]     to_cnt;
  logic              beat, to_fire;

  // Scan from rr_ptr upward; descending loop leaves the closest requester last.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    idx     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = OW'((int'(rr_ptr) + k) % NREQ);
      if (req_si[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    req_ri    = '0;
    rsp_so    = '0;
    llc_so    = 1'b0;
    llc_ro    = 1'b0;
    beat      = 1'b0;
    to_fire   = 1'b0;
    case (state)
      IDLE: begin
        if (win_vld && !reset) begin
          req_ri[win] = 1'b1;
          state_nxt   = ISSUE;
        end
      end
      ISSUE: begin
        llc_so = 1'b1;
        if (llc_ri) state_nxt = WAIT_RSP;
      end
      WAIT_RSP: begin
        // Ready toward the LLC never looks at llc_si, breaking the valid/ready loop.
        llc_ro          = rsp_ro[owner_q];
        rsp_so[owner_q] = llc_si;
        beat            = llc_si & rsp_ro[owner_q];
        if (beat) begin
          if (beat_cnt == 8'd1) state_nxt = IDLE;
        end else if (TO_CYC != 0 && to_cnt == TW'(TO_CYC - 1)) begin
          to_fire   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner_q  <= '0;
      hold     <= '0;
      beat_cnt <= '0;
      to_cnt   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (win_vld) begin
            hold    <= req_di[int'(win)*DATA_W +: DATA_W];
            owner_q <= win;
            rr_ptr  <= (win == OW'(NREQ - 1)) ? '0 : win + 1'b1;
          end
        end
        ISSUE: begin
          if (llc_ri) begin
            beat_cnt <= 8'(BURST);
            to_cnt   <= '0;
          end
        end
        WAIT_RSP: begin
          if (beat) begin
            beat_cnt <= beat_cnt - 8'd1;
            to_cnt   <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign llc_do = hold;
  assign rsp_do = llc_di;
  assign busy   = (state != IDLE);
  assign owner  = 3'(owner_q);
  assign to_err = to_fire;

endmodule

// File: tb/tb_llc_req_arbiter.sv
// Scenario bench for llc_req_arbiter: reply flits are queued as the LLC model
// drives them and popped as beats reach the owning requester.
module tb_llc_req_arbiter;

  localparam int DW = 64;
  localparam int N  = 4;
  localparam int B  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req_si, rsp_ro;
  logic [N*DW-1:0] req_di;
  logic          llc_ri, llc_si;
  logic [DW-1:0] llc_di;

  logic [N-1:0]  req_ri, rsp_so, t_req_ri, t_rsp_so;
  logic [DW-1:0] rsp_do, llc_do, t_rsp_do, t_llc_do;
  logic          llc_so, llc_ro, busy, to_err;
  logic          t_llc_so, t_llc_ro, t_busy, t_to_err;
  logic [2:0]    owner, t_owner;

  int n_chk  = 0;
  int n_fail = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  llc_req_arbiter #(.DATA_W(DW), .NREQ(N), .BURST(B), .TO_CYC(255)) dut (
    .clk(clk), .reset(reset), .req_si(req_si), .req_ri(req_ri), .req_di(req_di),
    .rsp_so(rsp_so), .rsp_ro(rsp_ro), .rsp_do(rsp_do), .llc_so(llc_so), .llc_ri(llc_ri),
    .llc_do(llc_do), .llc_si(llc_si), .llc_ro(llc_ro), .llc_di(llc_di), .busy(busy),
    .owner(owner), .to_err(to_err));

  llc_req_arbiter #(.DATA_W(DW), .NREQ(N), .BURST(B), .TO_CYC(8)) dut_to (
    .clk(clk), .reset(reset), .req_si(req_si), .req_ri(t_req_ri), .req_di(req_di),
    .rsp_so(t_rsp_so), .rsp_ro(rsp_ro), .rsp_do(t_rsp_do), .llc_so(t_llc_so), .llc_ri(llc_ri),
    .llc_do(t_llc_do), .llc_si(llc_si), .llc_ro(t_llc_ro), .llc_di(llc_di), .busy(t_busy),
    .owner(t_owner), .to_err(t_to_err));

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_flit(input int i, input logic [DW-1:0] v);
    req_di[i*DW +: DW] = v;
  endtask

  task automatic apply_reset();
    reset  = 1'b1;
    req_si = '0;
    rsp_ro = '1;
    llc_ri = 1'b0;
    llc_si = 1'b0;
    llc_di = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Current cycle must be IDLE; returns at the IDLE cycle after the last beat.
  task automatic do_txn(input int w, input logic [DW-1:0] fl, input bit drop, input int lat,
                        input int istall, input int bp_beat, input int bp_len, input string tag);
    logic [N-1:0] oh;
    logic [DW-1:0] f, got_f;
    int got;
    oh  = 4'b1 << w;
    got = 0;
    #1;
    n_chk++;
    if (req_ri !== oh) begin n_fail++; $display("FAIL %s grant: req_ri=%b want %b", tag, req_ri, oh); end
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL %s idle_busy: busy=%b want 0", tag, busy); end
    tick();
    if (drop) req_si = req_si & ~oh;
    for (int s = 0; s <= istall; s++) begin
      llc_ri = (s == istall);
      #1;
      n_chk++;
      if (llc_so !== 1'b1 || llc_do !== fl) begin
        n_fail++; $display("FAIL %s issue: llc_so=%b llc_do=%h want 1 %h", tag, llc_so, llc_do, fl);
      end
      n_chk++;
      if (owner !== 3'(w) || req_ri !== '0 || busy !== 1'b1) begin
        n_fail++; $display("FAIL %s issue_ctl: owner=%0d req_ri=%b busy=%b want %0d 0 1", tag, owner, req_ri, busy, w);
      end
      tick();
    end
    llc_ri = 1'b0;
    for (int c = 0; c < lat; c++) begin
      #1;
      n_chk++;
      if (llc_ro !== 1'b1 || llc_so !== 1'b0 || rsp_so !== '0 || to_err !== 1'b0) begin
        n_fail++; $display("FAIL %s wait: llc_ro=%b llc_so=%b rsp_so=%b to_err=%b want 1 0 0 0", tag, llc_ro, llc_so, rsp_so, to_err);
      end
      tick();
    end
    for (int b = 0; b < B; b++) begin
      f = {8'(w), 8'(b), 16'hBEEF, 32'($urandom)};
      llc_si = 1'b1;
      llc_di = f;
      exp_q.push_back(f);
      if (b == bp_beat) begin
        for (int c = 0; c < bp_len; c++) begin
          rsp_ro = ~oh;
          #1;
          n_chk++;
          if (llc_ro !== 1'b0 || rsp_so !== oh || to_err !== 1'b0) begin
            n_fail++; $display("FAIL %s stall: llc_ro=%b rsp_so=%b to_err=%b want 0 %b 0", tag, llc_ro, rsp_so, to_err, oh);
          end
          tick();
        end
        rsp_ro = '1;
      end
      #1;
      if (rsp_so == oh && llc_ro === 1'b1) begin
        got++;
        got_f = exp_q.pop_front();
        n_chk++;
        if (rsp_do !== got_f) begin n_fail++; $display("FAIL %s beat%0d: rsp_do=%h want %h", tag, b, rsp_do, got_f); end
      end else begin
        n_chk++; n_fail++;
        $display("FAIL %s beat%0d_hs: rsp_so=%b llc_ro=%b want %b 1", tag, b, rsp_so, llc_ro, oh);
      end
      tick();
    end
    llc_si = 1'b0;
    #1;
    n_chk++;
    if (got != B || exp_q.size() != 0) begin
      n_fail++; $display("FAIL %s beats: got=%0d left=%0d want %0d 0", tag, got, exp_q.size(), B);
    end
    n_chk++;
    if (busy !== 1'b0 || llc_so !== 1'b0 || rsp_so !== '0) begin
      n_fail++; $display("FAIL %s done: busy=%b llc_so=%b rsp_so=%b want 0 0 0", tag, busy, llc_so, rsp_so);
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    req_si = 4'hF;
    rsp_ro = '1;
    llc_ri = 1'b1;
    llc_si = 1'b1;
    llc_di = '0;
    req_di = '0;
    tick();
    tick();
    #1;
    n_chk++;
    if (req_ri !== '0 || rsp_so !== '0 || rsp_do !== '0 || llc_so !== 1'b0 || llc_do !== '0) begin
      n_fail++; $display("FAIL reset_data: req_ri=%b rsp_so=%b rsp_do=%h llc_so=%b llc_do=%h want 0", req_ri, rsp_so, rsp_do, llc_so, llc_do);
    end
    n_chk++;
    if (llc_ro !== 1'b0 || busy !== 1'b0 || owner !== 3'd0 || to_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctl: llc_ro=%b busy=%b owner=%0d to_err=%b want 0", llc_ro, busy, owner, to_err);
    end
    apply_reset();
  endtask

  task automatic test_single();
    apply_reset();
    set_flit(2, 64'hA5);
    req_si = 4'b0100;
    do_txn(2, 64'hA5, 1'b1, 3, 0, -1, 0, "single");
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int i = 0; i < N; i++) set_flit(i, {32'hC0DE0000, 32'(i)});
    req_si = 4'hF;
    for (int t = 0; t < 8; t++)
      do_txn(t % N, {32'hC0DE0000, 32'(t % N)}, 1'b0, int'($urandom_range(0, 3)), 0, -1, 0, "rr");
  endtask

  task automatic test_backpressure();
    apply_reset();
    set_flit(0, 64'h1234_5678_9ABC_DEF0);
    req_si = 4'b0001;
    do_txn(0, 64'h1234_5678_9ABC_DEF0, 1'b1, 2, 0, 1, 5, "bp");
  endtask

  task automatic test_issue_stall();
    apply_reset();
    set_flit(3, 64'hFEED_FACE_0000_0033);
    req_si = 4'b1000;
    do_txn(3, 64'hFEED_FACE_0000_0033, 1'b1, 1, 3, -1, 0, "istall");
  endtask

  task automatic test_timeout();
    apply_reset();
    set_flit(1, 64'h11);
    set_flit(2, 64'h22);
    req_si = 4'b0110;
    #1;
    n_chk++;
    if (t_req_ri !== 4'b0010) begin n_fail++; $display("FAIL to_grant: req_ri=%b want 0010", t_req_ri); end
    tick();
    llc_ri = 1'b1;
    tick();
    llc_ri = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      #1;
      n_chk++;
      if (t_to_err !== (k == 8) || t_busy !== 1'b1) begin
        n_fail++; $display("FAIL to_wait%0d: to_err=%b busy=%b want %b 1", k, t_to_err, t_busy, (k == 8));
      end
      tick();
    end
    #1;
    n_chk++;
    if (t_busy !== 1'b0 || t_to_err !== 1'b0 || t_req_ri !== 4'b0100) begin
      n_fail++; $display("FAIL to_after: busy=%b to_err=%b req_ri=%b want 0 0 0100", t_busy, t_to_err, t_req_ri);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    set_flit(0, 64'hDEAD_0000_0000_0001);
    set_flit(1, 64'hDEAD_0000_0000_0002);
    req_si = 4'b0001;
    tick();
    req_si = '0;
    llc_ri = 1'b1;
    tick();
    llc_ri = 1'b0;
    for (int b = 0; b < 2; b++) begin
      llc_si = 1'b1;
      llc_di = 64'h5000 + 64'(b);
      #1;
      n_chk++;
      if (rsp_so !== 4'b0001 || rsp_do !== 64'h5000 + 64'(b)) begin
        n_fail++; $display("FAIL mid_beat%0d: rsp_so=%b rsp_do=%h want 0001 %h", b, rsp_so, rsp_do, 64'h5000 + 64'(b));
      end
      tick();
    end
    llc_di = 64'h5002;
    reset  = 1'b1;
    tick();
    req_si = 4'b0011;
    #1;
    n_chk++;
    if (req_ri !== '0 || rsp_so !== '0 || llc_so !== 1'b0 || llc_do !== '0 || llc_ro !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_data: req_ri=%b rsp_so=%b llc_so=%b llc_do=%h llc_ro=%b want 0", req_ri, rsp_so, llc_so, llc_do, llc_ro);
    end
    n_chk++;
    if (busy !== 1'b0 || owner !== 3'd0 || to_err !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_ctl: busy=%b owner=%0d to_err=%b want 0", busy, owner, to_err);
    end
    tick();
    reset  = 1'b0;
    llc_si = 1'b0;
    #1;
    n_chk++;
    if (req_ri !== 4'b0001) begin n_fail++; $display("FAIL mid_regrant: req_ri=%b want 0001", req_ri); end
  endtask

  initial begin
    req_di = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_issue_stall();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
